// File: rtl/adv7513_config_sequencer.sv
// ---------------------------------------------------------------------------
// adv7513_config_sequencer
//
// Purpose:
//   Walks the ADV7513 configuration program ROM from address 0. Each 16-bit
//   word is decoded and executed:
//     16'hFFFF        END   : sequence finished, cfg_done_o set
//     16'hFEnn        DELAY : wait nn*DELAY_UNIT clocks (nn = 0 means no wait)
//     anything else   WRITE : register [15:8] <= data [7:0] via the I2C master
//   A NACKed write is re-issued up to MAX_RETRIES times, with RETRY_GAP idle
//   clocks before each re-issue. After that the sequencer stops in ERROR.
//
// Ports:
//   clk_i         system clock
//   reset_i       synchronous, active-high reset
//   rom_addr_o    config ROM address
//   rom_data_i    config ROM word, valid one clock after rom_addr_o changes
//   i2c_req_o     write request, held high until i2c_done_i
//   i2c_dev_o     7-bit device address (DEV_ADDR)
//   i2c_reg_o     register address (ROM word [15:8])
//   i2c_wdata_o   register data (ROM word [7:0])
//   i2c_done_i    one-clock pulse when the I2C transaction has finished
//   i2c_nack_i    qualifies i2c_done_i: 1 = device NACKed
//   cfg_busy_o    sequence in progress
//   cfg_done_o    END reached with no error (sticky)
//   cfg_error_o   retries exhausted (sticky)
//   hpd_i         HDMI hot-plug detect (only with ADV7513_CFG_HPD_REARM_EN)
//
// Configuration macro:
//   ADV7513_CFG_HPD_REARM_EN  adds hpd_i. A rising hot-plug edge restarts the
//   program from address 0: immediately from DONE/ERROR (no power-up wait),
//   or after the current write/delay has completed when the sequence is busy.
// ---------------------------------------------------------------------------
module adv7513_config_sequencer #(
   parameter logic [6:0]  DEV_ADDR       = 7'h39,
   parameter int unsigned POWERUP_CYCLES = 100_000,
   parameter int unsigned DELAY_UNIT     = 1_000,
   parameter int unsigned MAX_RETRIES    = 3,
   parameter int unsigned RETRY_GAP      = 1_000
) (
   input  logic        clk_i,
   input  logic        reset_i,
   output logic [7:0]  rom_addr_o,
   input  logic [15:0] rom_data_i,
   output logic        i2c_req_o,
   output logic [6:0]  i2c_dev_o,
   output logic [7:0]  i2c_reg_o,
   output logic [7:0]  i2c_wdata_o,
   input  logic        i2c_done_i,
   input  logic        i2c_nack_i,
   output logic        cfg_busy_o,
   output logic        cfg_done_o,
   output logic        cfg_error_o
`ifdef ADV7513_CFG_HPD_REARM_EN
   ,
   input  logic        hpd_i
`endif
);

   // One shared wait counter serves power-up, delay and retry gaps, so it is
   // sized for the longest of the three (a full 255-unit delay included).
   localparam longint unsigned DELAY_MAX  = 64'd255 * longint'(DELAY_UNIT);
   localparam longint unsigned WAIT_MAX_A = (longint'(POWERUP_CYCLES) > DELAY_MAX) ?
                                            longint'(POWERUP_CYCLES) : DELAY_MAX;
   localparam longint unsigned WAIT_MAX   = (longint'(RETRY_GAP) > WAIT_MAX_A) ?
                                            longint'(RETRY_GAP) : WAIT_MAX_A;
   localparam int CNT_W = $clog2(WAIT_MAX + 64'd1);
   localparam int RTY_W = (MAX_RETRIES == 0) ? 1 : $clog2(MAX_RETRIES + 1);

   localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(RETRY_GAP - 1);
   localparam logic [CNT_W-1:0] DU_C     = CNT_W'(DELAY_UNIT);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

   typedef enum logic [2:0] {
      ST_POWERUP,
      ST_FETCH,
      ST_DECODE,
      ST_WRITE,
      ST_RETRY,
      ST_DELAY,
      ST_DONE,
      ST_ERROR
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       romAddr_q, romAddr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] delayLast_q, delayLast_d;
   logic [RTY_W-1:0] retry_q, retry_d;
   logic             req_q, req_d;
   logic [7:0]       regAddr_q, regAddr_d;
   logic [7:0]       wdata_q, wdata_d;

   logic             advance;
   logic             doRestart;
   logic             hpdRise;
   logic             restartPending;
   logic             cfgActive;

   // Hot-plug re-arm exists only in the HPD build; otherwise the restart
   // terms are tied off so the main sequencer logic is identical in both.
   assign cfgActive = (state_q != ST_POWERUP) && (state_q != ST_DONE) &&
                      (state_q != ST_ERROR);

`ifdef ADV7513_CFG_HPD_REARM_EN
   logic hpdMeta_q, hpdSync_q, hpdPrev_q;
   logic rearm_q, rearm_d;

   // Two-flop synchroniser plus a delayed copy for rising-edge detection,
   // and the flag that remembers a hot-plug seen while a step was running.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         hpdMeta_q <= 1'b0;
         hpdSync_q <= 1'b0;
         hpdPrev_q <= 1'b0;
         rearm_q   <= 1'b0;
      end else begin
         hpdMeta_q <= hpd_i;
         hpdSync_q <= hpdMeta_q;
         hpdPrev_q <= hpdSync_q;
         rearm_q   <= rearm_d;
      end
   end

   assign hpdRise = hpdSync_q & ~hpdPrev_q;

   // The flag is consumed by the restart it triggers.
   always_comb begin
      rearm_d = rearm_q;
      if (doRestart) begin
         rearm_d = 1'b0;
      end else if (hpdRise && cfgActive) begin
         rearm_d = 1'b1;
      end
   end

   assign restartPending = rearm_q | (hpdRise & cfgActive);
`else
   assign hpdRise        = 1'b0;
   assign restartPending = 1'b0;
`endif

   // State and datapath registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= ST_POWERUP;
         romAddr_q   <= 8'd0;
         cnt_q       <= '0;
         delayLast_q <= '0;
         retry_q     <= '0;
         req_q       <= 1'b0;
         regAddr_q   <= 8'd0;
         wdata_q     <= 8'd0;
      end else begin
         state_q     <= state_d;
         romAddr_q   <= romAddr_d;
         cnt_q       <= cnt_d;
         delayLast_q <= delayLast_d;
         retry_q     <= retry_d;
         req_q       <= req_d;
         regAddr_q   <= regAddr_d;
         wdata_q     <= wdata_d;
      end
   end

   // Next-state logic. 'advance' marks a finished step (ACKed write or
   // elapsed delay); the common tail then moves to the next word, stops at
   // the top of the ROM, or restarts from 0 when a hot-plug is pending.
   always_comb begin
      state_d     = state_q;
      romAddr_d   = romAddr_q;
      cnt_d       = cnt_q;
      delayLast_d = delayLast_q;
      retry_d     = retry_q;
      req_d       = req_q;
      regAddr_d   = regAddr_q;
      wdata_d     = wdata_q;
      advance     = 1'b0;
      doRestart   = 1'b0;

      case (state_q)
         ST_POWERUP: begin
            if (cnt_q == PWR_LAST) begin
               cnt_d   = '0;
               state_d = ST_FETCH;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_FETCH: begin
            state_d = ST_DECODE;
         end

         ST_DECODE: begin
            if (rom_data_i == 16'hFFFF) begin
               if (restartPending) begin
                  doRestart = 1'b1;
               end else begin
                  state_d = ST_DONE;
               end
            end else if (rom_data_i[15:8] == 8'hFE) begin
               if (rom_data_i[7:0] == 8'd0) begin
                  advance = 1'b1;
               end else begin
                  delayLast_d = (CNT_W'(rom_data_i[7:0]) * DU_C) - CNT_W'(1);
                  cnt_d       = '0;
                  state_d     = ST_DELAY;
               end
            end else begin
               regAddr_d = rom_data_i[15:8];
               wdata_d   = rom_data_i[7:0];
               req_d     = 1'b1;
               retry_d   = '0;
               state_d   = ST_WRITE;
            end
         end

         ST_WRITE: begin
            if (i2c_done_i) begin
               req_d = 1'b0;
               if (!i2c_nack_i) begin
                  retry_d = '0;
                  advance = 1'b1;
               end else if (retry_q < RTY_MAX) begin
                  retry_d = retry_q + RTY_W'(1);
                  cnt_d   = '0;
                  state_d = ST_RETRY;
               end else if (restartPending) begin
                  doRestart = 1'b1;
               end else begin
                  state_d = ST_ERROR;
               end
            end
         end

         ST_RETRY: begin
            if (cnt_q == GAP_LAST) begin
               req_d   = 1'b1;
               state_d = ST_WRITE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_DELAY: begin
            if (cnt_q == delayLast_q) begin
               advance = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_DONE, ST_ERROR: begin
            if (hpdRise) begin
               doRestart = 1'b1;
            end
         end

         default: begin
            state_d = ST_POWERUP;
         end
      endcase

      if (advance) begin
         if (restartPending) begin
            doRestart = 1'b1;
         end else if (romAddr_q == 8'hFF) begin
            state_d = ST_DONE;
         end else begin
            romAddr_d = romAddr_q + 8'd1;
            state_d   = ST_FETCH;
         end
      end

      if (doRestart) begin
         romAddr_d = 8'd0;
         state_d   = ST_FETCH;
      end
   end

   assign rom_addr_o  = romAddr_q;
   assign i2c_req_o   = req_q;
   assign i2c_dev_o   = DEV_ADDR;
   assign i2c_reg_o   = regAddr_q;
   assign i2c_wdata_o = wdata_q;
   assign cfg_busy_o  = (state_q != ST_DONE) && (state_q != ST_ERROR);
   assign cfg_done_o  = (state_q == ST_DONE);
   assign cfg_error_o = (state_q == ST_ERROR);

endmodule

// File: tb/tb_adv7513_config_sequencer.sv
// ---------------------------------------------------------------------------
// tb_adv7513_config_sequencer
//
// Directed bench for the ADV7513 config sequencer. A registered ROM model
// feeds the DUT; every WRITE word loaded into the ROM is pushed onto a
// scoreboard queue and popped when the I2C responder ACKs the matching
// request. Small timing parameters keep the run short.
// ---------------------------------------------------------------------------
module tb_adv7513_config_sequencer;

   localparam int         P   = 50;
   localparam int         DU  = 10;
   localparam int         MR  = 3;
   localparam int         GAP = 12;
   localparam logic [6:0] DEV = 7'h39;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  romAddr;
   logic [15:0] romData;
   logic        i2cReq;
   logic [6:0]  i2cDev;
   logic [7:0]  i2cReg;
   logic [7:0]  i2cWdata;
   logic        i2cDone = 1'b0;
   logic        i2cNack = 1'b0;
   logic        cfgBusy;
   logic        cfgDone;
   logic        cfgError;
`ifdef ADV7513_CFG_HPD_REARM_EN
   logic        hpd = 1'b0;
`endif

   logic [15:0] rom [256];
   logic [15:0] expQ [$];
   int          nAsserts = 0;
   int          nFails = 0;

   adv7513_config_sequencer #(
      .DEV_ADDR       (DEV),
      .POWERUP_CYCLES (P),
      .DELAY_UNIT     (DU),
      .MAX_RETRIES    (MR),
      .RETRY_GAP      (GAP)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .rom_addr_o  (romAddr),
      .rom_data_i  (romData),
      .i2c_req_o   (i2cReq),
      .i2c_dev_o   (i2cDev),
      .i2c_reg_o   (i2cReg),
      .i2c_wdata_o (i2cWdata),
      .i2c_done_i  (i2cDone),
      .i2c_nack_i  (i2cNack),
      .cfg_busy_o  (cfgBusy),
      .cfg_done_o  (cfgDone),
      .cfg_error_o (cfgError)
`ifdef ADV7513_CFG_HPD_REARM_EN
      ,
      .hpd_i       (hpd)
`endif
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Config ROM with a one-clock registered read.
   always @(posedge clk) romData <= rom[romAddr];

   // Hard stop in case something stalls outside the bounded waits.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed still running expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nAsserts++;
      assert (observed === expected)
      else begin
         nFails++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic clearProgram();
      for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
      expQ.delete();
   endtask

   // Loads one ROM word at the next free address; writes go to the scoreboard.
   int progLen = 0;
   task automatic applyStimulus(input logic [15:0] word);
      rom[progLen[7:0]] = word;
      progLen++;
      if (word != 16'hFFFF && word[15:8] != 8'hFE) expQ.push_back(word);
   endtask

   task automatic resetDut();
      @(negedge clk);
      reset   = 1'b1;
      i2cDone = 1'b0;
      i2cNack = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " rom_addr"}, romAddr, 8'h00);
      checkOutput({tag, " i2c_req"}, i2cReq, 1'b0);
      checkOutput({tag, " i2c_reg"}, i2cReg, 8'h00);
      checkOutput({tag, " i2c_wdata"}, i2cWdata, 8'h00);
      checkOutput({tag, " cfg_busy"}, cfgBusy, 1'b1);
      checkOutput({tag, " cfg_done"}, cfgDone, 1'b0);
      checkOutput({tag, " cfg_error"}, cfgError, 1'b0);
   endtask

   task automatic waitReq(input int budget, output int cycles);
      cycles = 0;
      while (!i2cReq && cycles < budget) begin
         @(negedge clk);
         cycles++;
      end
      if (!i2cReq) checkOutput("i2c_req timeout", i2cReq, 1'b1);
   endtask

   task automatic waitDoneFlag(input int budget, output int cycles);
      cycles = 0;
      while (!cfgDone && cycles < budget) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("cfg_done reached", cfgDone, 1'b1);
   endtask

   // I2C responder: waits for a request, checks it against the scoreboard
   // head, answers after 'latency' clocks and pops the entry on ACK.
   task automatic serviceWrite(input int latency, input bit nack, output int waitCycles);
      logic [15:0] exp;
      waitReq(400, waitCycles);
      if (!i2cReq) return;
      exp = (expQ.size() > 0) ? expQ[0] : 16'hxxxx;
      checkOutput("i2c_dev", i2cDev, DEV);
      checkOutput("i2c_reg", i2cReg, exp[15:8]);
      checkOutput("i2c_wdata", i2cWdata, exp[7:0]);
      repeat (latency) @(negedge clk);
      checkOutput("i2c_req held", i2cReq, 1'b1);
      checkOutput("i2c_reg held", i2cReg, exp[15:8]);
      i2cDone = 1'b1;
      i2cNack = nack;
      @(negedge clk);
      i2cDone = 1'b0;
      i2cNack = 1'b0;
      checkOutput("i2c_req drop", i2cReq, 1'b0);
      if (!nack && expQ.size() > 0) void'(expQ.pop_front());
   endtask

   task automatic countReqs(input int cycles, output int seen);
      seen = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (i2cReq) seen++;
      end
   endtask

   initial begin
      int w;
      int seen;
      int addrCycle;
      int doneCycle;

      // Two writes then END; first request lands P+2 clocks after reset.
      $display("[TB] two writes then END");
      clearProgram();
      progLen = 0;
      applyStimulus(16'h4110);
      applyStimulus(16'h9803);
      applyStimulus(16'hFFFF);
      resetDut();
      checkResetValues("reset");
      reset = 1'b0;
      serviceWrite(20, 1'b0, w);
      checkOutput("first req cycle", w, P + 2);
      serviceWrite(20, 1'b0, w);
      checkOutput("fetch+decode latency", w, 2);
      waitDoneFlag(20, w);
      checkOutput("done after last ack", w, 2);
      checkOutput("done busy", cfgBusy, 1'b0);
      checkOutput("done error", cfgError, 1'b0);
      countReqs(30, seen);
      checkOutput("no req from END", seen, 0);
      checkOutput("scoreboard empty t1", expQ.size(), 0);

      // DELAY of 3 units: no request, address advances after 3*DU clocks.
      $display("[TB] delay word");
      clearProgram();
      progLen = 0;
      applyStimulus(16'hFE03);
      applyStimulus(16'hFFFF);
      resetDut();
      reset = 1'b0;
      seen = 0;
      addrCycle = -1;
      doneCycle = -1;
      for (int k = 1; k <= 300 && doneCycle < 0; k++) begin
         @(negedge clk);
         i2cDone = (k == 60);
         if (i2cReq) seen++;
         if (romAddr == 8'd1 && addrCycle < 0) addrCycle = k;
         if (cfgDone) doneCycle = k;
      end
      i2cDone = 1'b0;
      checkOutput("delay no req", seen, 0);
      checkOutput("delay addr advance", addrCycle, P + 2 + 3 * DU);
      checkOutput("delay done cycle", doneCycle, P + 2 + 3 * DU + 2);

      // Two NACKs then ACK: same register three times, RETRY_GAP apart.
      $display("[TB] retry then advance");
      clearProgram();
      progLen = 0;
      applyStimulus(16'h5501);
      applyStimulus(16'h6602);
      applyStimulus(16'hFFFF);
      resetDut();
      reset = 1'b0;
      serviceWrite(5, 1'b1, w);
      checkOutput("retry first req", w, P + 2);
      serviceWrite(5, 1'b1, w);
      checkOutput("retry gap 1", w, GAP);
      serviceWrite(5, 1'b0, w);
      checkOutput("retry gap 2", w, GAP);
      checkOutput("addr after retried ack", romAddr, 8'd1);
      serviceWrite(5, 1'b0, w);
      checkOutput("next write latency", w, 2);
      waitDoneFlag(20, w);
      checkOutput("retry done error", cfgError, 1'b0);
      checkOutput("scoreboard empty t4", expQ.size(), 0);

      // Four NACKs exhaust the retries.
      $display("[TB] retries exhausted");
      clearProgram();
      progLen = 0;
      applyStimulus(16'h7707);
      applyStimulus(16'hFFFF);
      resetDut();
      reset = 1'b0;
      for (int n = 0; n < MR + 1; n++) serviceWrite(3, 1'b1, w);
      checkOutput("error flag", cfgError, 1'b1);
      checkOutput("error done", cfgDone, 1'b0);
      checkOutput("error busy", cfgBusy, 1'b0);
      checkOutput("error addr", romAddr, 8'd0);
      void'(expQ.pop_front());
      countReqs(30, seen);
      checkOutput("error no req", seen, 0);
      checkOutput("error addr frozen", romAddr, 8'd0);
      checkOutput("error sticky", cfgError, 1'b1);

      // Reset in the middle of a write, then a clean rerun.
      $display("[TB] reset mid-write");
      clearProgram();
      progLen = 0;
      applyStimulus(16'h4110);
      applyStimulus(16'h9803);
      applyStimulus(16'hFFFF);
      resetDut();
      reset = 1'b0;
      waitReq(400, w);
      checkOutput("pre-reset req cycle", w, P + 2);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkResetValues("mid-write reset");
      reset = 1'b0;
      serviceWrite(20, 1'b0, w);
      checkOutput("rerun first req", w, P + 2);
      serviceWrite(20, 1'b0, w);
      waitDoneFlag(20, w);
      checkOutput("rerun done latency", w, 2);
      checkOutput("scoreboard empty t5", expQ.size(), 0);

      // 256 writes with no END: last word executes, then DONE at addr 255.
      $display("[TB] full ROM without END");
      clearProgram();
      progLen = 0;
      for (int i = 0; i < 256; i++) begin
         applyStimulus((i == 0) ? 16'h0000 : {1'b0, 7'(i), 8'(i)});
      end
      resetDut();
      reset = 1'b0;
      for (int i = 0; i < 256; i++) serviceWrite(0, 1'b0, w);
      checkOutput("wrap done", cfgDone, 1'b1);
      checkOutput("wrap addr", romAddr, 8'hFF);
      checkOutput("scoreboard empty wrap", expQ.size(), 0);
      countReqs(20, seen);
      checkOutput("wrap no req", seen, 0);

`ifdef ADV7513_CFG_HPD_REARM_EN
      // Hot-plug during a write restarts from 0 once the write completes,
      // and a hot-plug in DONE restarts without the power-up wait.
      $display("[TB] hot-plug re-arm");
      clearProgram();
      progLen = 0;
      applyStimulus(16'h4110);
      applyStimulus(16'h9803);
      applyStimulus(16'hFFFF);
      resetDut();
      hpd = 1'b0;
      reset = 1'b0;
      waitReq(400, w);
      hpd = 1'b1;
      serviceWrite(10, 1'b0, w);
      checkOutput("hpd restart addr", romAddr, 8'd0);
      expQ.push_front(16'h4110);
      serviceWrite(5, 1'b0, w);
      checkOutput("hpd restart latency", w, 2);
      serviceWrite(5, 1'b0, w);
      waitDoneFlag(20, w);
      hpd = 1'b0;
      repeat (5) @(negedge clk);
      hpd = 1'b1;
      expQ.push_back(16'h4110);
      expQ.push_back(16'h9803);
      serviceWrite(5, 1'b0, w);
      checkOutput("hpd rearm from done", w, 5);
      serviceWrite(5, 1'b0, w);
      waitDoneFlag(20, w);
      checkOutput("hpd redone latency", w, 2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
